seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx.sv | 166 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_tx
// Description : Serial pattern transmitter. Latches a WIDTH-bit pattern on a
//               start request and sends it MSB-first, one bit per clock,
//               repeating the frame back-to-back 'rep' times (0 acts as 1).
//               Moore machine; every output is a register.
//               Optional feature macro: SEQ_TX_PARITY_EN appends one
//               even-parity bit to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
    parameter int   WIDTH    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [3:0]       rep,
    output logic             y,
    output logic             y_valid,
    output logic             busy,
    output logic             done
);

    localparam int                C_BW   = $clog2(WIDTH + 1);
    localparam logic [C_BW-1:0]   C_LAST = C_BW'(WIDTH - 1);
    localparam logic [C_BW-1:0]   C_ONE  = C_BW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [WIDTH-1:0] pat_q,   pat_d;
    logic [C_BW-1:0]  bit_q,   bit_d;
    logic [4:0]       frm_q,   frm_d;
    logic             y_q,     y_d;
    logic             yv_q,    yv_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Next-state, datapath and next-output computation; outputs are derived
    // from the next state so they are registered alongside it.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        pat_d   = pat_q;
        bit_d   = bit_q;
        frm_d   = frm_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sreg_d  = pat_in;
                    pat_d   = pat_in;
                    frm_d   = (rep == 4'd0) ? 5'd1 : {1'b0, rep};
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sreg_d = sreg_q << 1;
                bit_d  = bit_q + C_ONE;
                if (bit_q == C_LAST) begin
                    bit_d = '0;
`ifdef SEQ_TX_PARITY_EN
                    state_d = S_PAR;
`else
                    if (frm_q > 5'd1) begin
                        frm_d   = frm_q - 5'd1;
                        sreg_d  = pat_q;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                bit_d = '0;
                if (frm_q > 5'd1) begin
                    frm_d   = frm_q - 5'd1;
                    sreg_d  = pat_q;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                bit_d   = '0;
                frm_d   = '0;
            end
        endcase

        // Output values for the state being entered.
        y_d    = IDLE_BIT;
        yv_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_SHIFT: begin
                y_d    = sreg_d[WIDTH-1];
                yv_d   = 1'b1;
                busy_d = 1'b1;
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                y_d    = ^pat_d;
                yv_d   = 1'b1;
                busy_d = 1'b1;
            end
`endif
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                y_d = IDLE_BIT;
            end
        endcase
    end

    // State, datapath and output registers; reset acts immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            pat_q   <= '0;
            bit_q   <= '0;
            frm_q   <= '0;
            y_q     <= IDLE_BIT;
            yv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            pat_q   <= pat_d;
            bit_q   <= bit_d;
            frm_q   <= frm_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y       = y_q;
    assign y_valid = yv_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pattern_tx
// Description : Directed self-checking bench for seq_pattern_tx (WIDTH=4,
//               IDLE_BIT=0). Expected bit streams are written out by hand;
//               SEQ_TX_PARITY_EN selects the parity variants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] pat_in;
    logic [3:0] rep;
    logic       y;
    logic       y_valid;
    logic       busy;
    logic       done;

    int n_total;
    int n_bad;

    seq_pattern_tx #(
        .WIDTH    (4),
        .IDLE_BIT (1'b0)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pat_in  (pat_in),
        .rep     (rep),
        .y       (y),
        .y_valid (y_valid),
        .busy    (busy),
        .done    (done)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Check one transmitted bit at the current negedge, then advance.
    task automatic bit_chk(input string tag, input int idx, input logic e);
        chk($sformatf("%s y[%0d]", tag, idx), y, e);
        chk($sformatf("%s y_valid[%0d]", tag, idx), y_valid, 1'b1);
        chk($sformatf("%s busy[%0d]", tag, idx), busy, 1'b1);
        chk($sformatf("%s done[%0d]", tag, idx), done, 1'b0);
        @(negedge clk);
    endtask

    // Check the DONE cycle and the following IDLE cycle, ending on a negedge.
    task automatic end_chk(input string tag);
        chk({tag, " done_pulse"}, done, 1'b1);
        chk({tag, " done_busy"}, busy, 1'b1);
        chk({tag, " done_yv"}, y_valid, 1'b0);
        chk({tag, " done_y"}, y, 1'b0);
        @(negedge clk);
        chk({tag, " idle_done"}, done, 1'b0);
        chk({tag, " idle_busy"}, busy, 1'b0);
        chk({tag, " idle_y"}, y, 1'b0);
    endtask

    // Start a transfer and check the whole stream exp[n-1] .. exp[0].
    // pat_in/rep are scrambled after the start edge to prove they are latched.
    task automatic send_chk(input string tag, input logic [3:0] pat, input logic [3:0] r,
                            input logic [63:0] exp, input int n);
        start  = 1'b1;
        pat_in = pat;
        rep    = r;
        @(negedge clk);
        start  = 1'b0;
        pat_in = ~pat;
        rep    = 4'd7;
        for (int i = 0; i < n; i++) begin
            bit_chk(tag, i, exp[n-1-i]);
        end
        end_chk(tag);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        pat_in  = 4'd0;
        rep     = 4'd0;
        @(negedge clk);
        chk("rst y", y, 1'b0);
        chk("rst y_valid", y_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst busy", busy, 1'b0);

`ifdef SEQ_TX_PARITY_EN
        send_chk("p1001r1", 4'b1001, 4'd1, 64'b10010, 5);
        send_chk("p1001r2", 4'b1001, 4'd2, 64'b1001010010, 10);
        send_chk("p0110r0", 4'b0110, 4'd0, 64'b01100, 5);
        send_chk("p1010r3", 4'b1010, 4'd3, 64'b101001010010100, 15);
        send_chk("p1011r1", 4'b1011, 4'd1, 64'b10111, 5);
`else
        send_chk("p1001r1", 4'b1001, 4'd1, 64'b1001, 4);
        send_chk("p1001r2", 4'b1001, 4'd2, 64'b10011001, 8);
        send_chk("p0110r0", 4'b0110, 4'd0, 64'b0110, 4);
        send_chk("p1010r3", 4'b1010, 4'd3, 64'b101010101010, 12);
        send_chk("p1011r1", 4'b1011, 4'd1, 64'b1011, 4);
`endif

        // start held high; pat_in changes mid-frame; second transfer only after IDLE.
        start  = 1'b1;
        pat_in = 4'b1100;
        rep    = 4'd1;
        @(negedge clk);
        bit_chk("hold1", 0, 1'b1);
        pat_in = 4'b0011;
        bit_chk("hold1", 1, 1'b1);
        bit_chk("hold1", 2, 1'b0);
        bit_chk("hold1", 3, 1'b0);
`ifdef SEQ_TX_PARITY_EN
        bit_chk("hold1", 4, 1'b0);
`endif
        chk("hold1 done_pulse", done, 1'b1);
        @(negedge clk);
        chk("hold1 idle_busy", busy, 1'b0);
        chk("hold1 idle_yv", y_valid, 1'b0);
        @(negedge clk);
        start = 1'b0;
        bit_chk("hold2", 0, 1'b0);
        bit_chk("hold2", 1, 1'b0);
        bit_chk("hold2", 2, 1'b1);
        bit_chk("hold2", 3, 1'b1);
`ifdef SEQ_TX_PARITY_EN
        bit_chk("hold2", 4, 1'b0);
`endif
        end_chk("hold2");

        // Asynchronous reset during the third bit of a 1001 frame.
        start  = 1'b1;
        pat_in = 4'b1001;
        rep    = 4'd1;
        @(negedge clk);
        start = 1'b0;
        bit_chk("arst", 0, 1'b1);
        bit_chk("arst", 1, 1'b0);
        chk("arst pre busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst y", y, 1'b0);
        chk("arst y_valid", y_valid, 1'b0);
        chk("arst busy", busy, 1'b0);
        chk("arst done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("arst quiet done[%0d]", i), done, 1'b0);
            chk($sformatf("arst quiet busy[%0d]", i), busy, 1'b0);
        end
`ifdef SEQ_TX_PARITY_EN
        send_chk("fresh", 4'b1001, 4'd1, 64'b10010, 5);
`else
        send_chk("fresh", 4'b1001, 4'd1, 64'b1001, 4);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
